fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Front end that feeds the Backend instruction stream: fetches from instruction memory at a PC,
//  buffers words in a small queue, presents head with valid/dequeue handshake. Honours restart
//  (branch/reset redirect) by flushing queue and discarding in-flight reads. Also services
//  Backend load/store requests into instruction memory, with priority over fetch.
// PARAMETERS
//  I_WIDTH    13  instruction / imem word width
//  IA_WIDTH   10  instruction address width (PC, restart, load/store address)
//  DEPTH      4   instruction queue entries (power of 2, >=2)
// PORTS
//  clk                  in   1         clock, all state on rising edge
//  reset_i              in   1         asynchronous, active-low reset (0 = reset)
//  instruction_data_o   out  I_WIDTH   queue head instruction
//  instruction_addr_o   out  IA_WIDTH  address of queue head
//  instruction_valid_o  out  1         queue head valid
//  dequeue_i            in   1         Backend consumed head this cycle
//  restart_i            in   1         redirect fetch to restart_addr_i
//  restart_addr_i       in   IA_WIDTH  redirect target
//  load_store_valid_i   in   1         imem access request from Backend
//  store_en_i           in   1         1 = store, 0 = load
//  load_store_addr_i    in   IA_WIDTH  access address
//  store_data_i         in   I_WIDTH   store word
//  load_data_o          out  I_WIDTH   load result
//  load_data_valid_o    out  1         load result valid (1-cycle pulse)
//  imem_addr_o          out  IA_WIDTH  imem address
//  imem_rd_en_o         out  1         imem read strobe; data 1 cycle later
//  imem_wr_en_o         out  1         imem write strobe
//  imem_wr_data_o       out  I_WIDTH   imem write data
//  imem_data_i          in   I_WIDTH   imem read data (registered, latency 1)
// BEHAVIOUR
//  - Reset: PC=0, queue empty, in-flight cleared, epoch=0; all outputs 0.
//  - Port arbitration per cycle: load_store_valid_i wins imem; else fetch read issued at PC if
//    count + inflight < DEPTH (credit check); then PC <= PC+1, wraps 2^IA_WIDTH-1 -> 0.
//  - Each read carries epoch tag + kind (fetch/load); returned word 1 cycle later is pushed to
//    queue (fetch, tag == epoch) or driven on load_data_o with load_data_valid_o=1 (load).
//  - Stale fetch data (tag != epoch) dropped, credit released.
//  - Head: instruction_valid_o = !empty; data/addr stable while valid && !dequeue_i.
//  - dequeue_i with valid=0 ignored. Push and pop same cycle: count unchanged.
//  - Restart: queue flushed next edge, epoch toggled, PC <= restart_addr_i; first fetch of new
//    target issued same cycle if imem free. Earliest valid: 2 cycles after restart asserted.
//  - Restart + dequeue same cycle: restart wins; pop has no extra effect.
//  - Restart + store same cycle: store completes; fetch of new PC next cycle.
//  - Restart held several cycles: PC reloaded each cycle, queue stays empty.
//  - Reset mid-operation: immediate async clear; pending load result lost, no valid pulse.
// CONFIGURATION
//  - FETCH_STATS_EN defined: adds restart_count_o [15:0] (restart cycles) and
//    stall_count_o [15:0] (cycles valid=0, no restart); saturate at 16'hFFFF; reset 0.
//  - Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  - Reset released, imem[i]=i+100, dequeue_i=1 always -> valid from cycle 2; addrs 0,1,2...
//    data 100,101,102... back-to-back.
//  - dequeue_i=0 for 10 cycles -> exactly DEPTH=4 entries; imem_rd_en_o low once full; head addr 0.
//  - Restart to 0x200 while queue holds 0..3 + read in flight -> in-flight word dropped;
//    next valid head addr 0x200.
//  - Store 13'h1ABC to 0x005 during streaming -> imem_wr_en_o pulse; fetch stalls 1 cycle;
//    later load of 0x005 returns 0x1ABC with one valid pulse.
//  - PC at 0x3FF with dequeue_i=1 -> next addrs 0x3FF, 0x000, 0x001.
//  - reset_i low mid-stream -> valid_o, load_data_valid_o drop same cycle; restart after release
//    fetches from 0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC-driven imem reads into a small queue, restart
// flush via epoch tagging, and Backend load/store access. Optional FETCH_STATS_EN.
module fetch_unit #(
  parameter int I_WIDTH  = 13,
  parameter int IA_WIDTH = 10,
  parameter int DEPTH    = 4
) (
  input  logic                clk,
  input  logic                reset_i,
  output logic [I_WIDTH-1:0]  instruction_data_o,
  output logic [IA_WIDTH-1:0] instruction_addr_o,
  output logic                instruction_valid_o,
  input  logic                dequeue_i,
  input  logic                restart_i,
  input  logic [IA_WIDTH-1:0] restart_addr_i,
  input  logic                load_store_valid_i,
  input  logic                store_en_i,
  input  logic [IA_WIDTH-1:0] load_store_addr_i,
  input  logic [I_WIDTH-1:0]  store_data_i,
  output logic [I_WIDTH-1:0]  load_data_o,
  output logic                load_data_valid_o,
  output logic [IA_WIDTH-1:0] imem_addr_o,
  output logic                imem_rd_en_o,
  output logic                imem_wr_en_o,
  output logic [I_WIDTH-1:0]  imem_wr_data_o,
  input  logic [I_WIDTH-1:0]  imem_data_i
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]         restart_count_o,
  output logic [15:0]         stall_count_o
`endif
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic {KIND_FETCH, KIND_LOAD} kind_e;

  logic [IA_WIDTH-1:0] pc;
  logic                epoch;
  logic [PW-1:0]       rd_ptr, wr_ptr;
  logic [PW:0]         count;

  logic                pend;
  kind_e               pend_kind;
  logic                pend_epoch;
  logic [IA_WIDTH-1:0] pend_addr;

  logic [I_WIDTH-1:0]  q_data [DEPTH];
  logic [IA_WIDTH-1:0] q_addr [DEPTH];

  logic [IA_WIDTH-1:0] fetch_pc;
  logic [PW+1:0]       occ;
  logic                infl, credit, fetch_go, ls_rd, push, pop;

  always_comb begin
    fetch_pc = restart_i ? restart_addr_i : pc;
    infl     = pend && (pend_kind == KIND_FETCH);
    occ      = (PW+2)'(count) + (PW+2)'(infl);
    // a restart discards both the queue and the returning read, so credit is full
    credit   = restart_i || (occ < (PW+2)'(DEPTH));
    fetch_go = reset_i && !load_store_valid_i && credit;
    ls_rd    = reset_i && load_store_valid_i && !store_en_i;
    push     = infl && (pend_epoch == epoch) && !restart_i;
    pop      = (count != '0) && dequeue_i && !restart_i;
  end

  always_comb begin
    imem_rd_en_o   = fetch_go || ls_rd;
    imem_wr_en_o   = reset_i && load_store_valid_i && store_en_i;
    imem_wr_data_o = imem_wr_en_o ? store_data_i : '0;
    if (!reset_i)
      imem_addr_o = '0;
    else if (load_store_valid_i)
      imem_addr_o = load_store_addr_i;
    else if (fetch_go)
      imem_addr_o = fetch_pc;
    else
      imem_addr_o = '0;

    load_data_valid_o   = pend && (pend_kind == KIND_LOAD);
    load_data_o         = load_data_valid_o ? imem_data_i : '0;
    instruction_valid_o = (count != '0);
    instruction_data_o  = instruction_valid_o ? q_data[rd_ptr] : '0;
    instruction_addr_o  = instruction_valid_o ? q_addr[rd_ptr] : '0;
  end

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      pc         <= '0;
      epoch      <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      pend       <= 1'b0;
      pend_kind  <= KIND_FETCH;
      pend_epoch <= 1'b0;
      pend_addr  <= '0;
    end else begin
      pend       <= fetch_go || ls_rd;
      pend_kind  <= ls_rd ? KIND_LOAD : KIND_FETCH;
      pend_epoch <= restart_i ? ~epoch : epoch;
      pend_addr  <= fetch_pc;
      if (restart_i) begin
        epoch  <= ~epoch;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        pc     <= fetch_go ? restart_addr_i + 1'b1 : restart_addr_i;
      end else begin
        if (fetch_go)
          pc <= pc + 1'b1;
        if (push)
          wr_ptr <= wr_ptr + 1'b1;
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wr_ptr] <= imem_data_i;
      q_addr[wr_ptr] <= pend_addr;
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      restart_count_o <= '0;
      stall_count_o   <= '0;
    end else begin
      if (restart_i && restart_count_o != '1)
        restart_count_o <= restart_count_o + 1'b1;
      if (!instruction_valid_o && !restart_i && stall_count_o != '1)
        stall_count_o <= stall_count_o + 1'b1;
    end
  end
`endif

endmodule
